// File: rtl/jtframe_rom_arb.sv
// Round-robin arbiter sharing one SDRAM ROM read port among four requesters.
// Each slot keeps a one-word cache so repeated reads of the same word skip the SDRAM.
module jtframe_rom_arb #(
    parameter int              AW      = 22,
    parameter logic [AW-1:0]   OFFSET0 = 22'd0,
    parameter logic [AW-1:0]   OFFSET1 = 22'd0,
    parameter logic [AW-1:0]   OFFSET2 = 22'd0,
    parameter logic [AW-1:0]   OFFSET3 = 22'd0
) (
    input  logic              clk_rom,
    input  logic              rst,
    input  logic              downloading,
    input  logic              loop_rst,
    input  logic [3:0]        slot_cs,
    input  logic [4*AW-1:0]   slot_addr,
    output logic [3:0]        slot_ok,
    output logic [127:0]      slot_dout,
    output logic              sdram_req,
    input  logic              sdram_ack,
    output logic [AW-1:0]     sdram_addr,
    input  logic [31:0]       data_read,
    input  logic              data_rdy,
    output logic              refresh_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [AW-1:0] OFFSETS [4] = '{OFFSET0, OFFSET1, OFFSET2, OFFSET3};

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      rr_q, rr_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
    logic            sdram_req_q, sdram_req_d;
    logic            refresh_q, refresh_d;
    logic [3:0]      valid_q, valid_d;
    logic [AW-1:0]   cache_addr_q [4];
    logic [AW-1:0]   cache_addr_d [4];
    logic [31:0]     dout_q [4];
    logic [31:0]     dout_d [4];

    logic [3:0]      hit;
    logic [3:0]      pending;
    logic            found;
    logic [1:0]      pick;
    logic [1:0]      idx;
    logic [AW-1:0]   pick_addr;
    logic            complete;
    logic            flush;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i] = valid_q[i] && (cache_addr_q[i] == slot_addr[i*AW +: AW]);
        end
        pending = slot_cs & ~hit;
    end

    // State register
    always_ff @(posedge clk_rom) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            rr_q         <= 2'd3;
            raddr_q      <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
            refresh_q    <= 1'b1;
            valid_q      <= 4'd0;
            // NOTE: the cache storage is reset because slot_dout is a visible output with a defined reset value.
            cache_addr_q <= '{default: '0};
            dout_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            raddr_q      <= raddr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
            refresh_q    <= refresh_d;
            valid_q      <= valid_d;
            cache_addr_q <= cache_addr_d;
            dout_q       <= dout_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        raddr_d      = raddr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        valid_d      = valid_q;
        cache_addr_d = cache_addr_q;
        dout_d       = dout_q;
        complete     = 1'b0;
        found        = 1'b0;
        pick         = 2'd0;
        idx          = 2'd0;
        flush        = downloading | loop_rst;

        // First pending slot strictly after the last grant, wrapping 3 -> 0
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_addr = slot_addr[pick*AW +: AW];

        if (flush) begin
            state_d     = ST_IDLE;
            sdram_req_d = 1'b0;
            valid_d     = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_d      = pick;
                        raddr_d      = pick_addr;
                        sdram_addr_d = pick_addr + OFFSETS[pick];
                        sdram_req_d  = 1'b1;
                        rr_d         = pick;
                        state_d      = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req_d = 1'b0;
                        if (data_rdy) complete = 1'b1;
                        else          state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) complete = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Data is cached under the address latched at grant time, not the live one
        if (complete) begin
            state_d               = ST_IDLE;
            dout_d[grant_q]       = data_read;
            cache_addr_d[grant_q] = raddr_q;
            valid_d[grant_q]      = 1'b1;
        end

        refresh_d = (state_q == ST_IDLE) && (pending == 4'd0);
    end

    // Outputs
    always_comb begin
        slot_ok = slot_cs & hit;
        for (int i = 0; i < 4; i++) begin
            slot_dout[i*32 +: 32] = dout_q[i];
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Self-checking bench for jtframe_rom_arb: directed scenarios plus a randomized
// run against a slot-level cache/round-robin reference model.
module tb_jtframe_rom_arb;

    localparam int AW = 22;
    localparam logic [21:0] OFF0 = 22'h010000;
    localparam logic [21:0] OFF1 = 22'h3FFFF0;
    localparam logic [21:0] OFF2 = 22'h000000;
    localparam logic [21:0] OFF3 = 22'h000400;
    localparam logic [21:0] OFFS [4] = '{OFF0, OFF1, OFF2, OFF3};

    logic          clk = 1'b0;
    logic          rst;
    logic          downloading;
    logic          loop_rst;
    logic [3:0]    slot_cs;
    logic [87:0]   slot_addr;
    logic [3:0]    slot_ok;
    logic [127:0]  slot_dout;
    logic          sdram_req;
    logic          sdram_ack;
    logic [21:0]   sdram_addr;
    logic [31:0]   data_read;
    logic          data_rdy;
    logic          refresh_en;

    int checks   = 0;
    int failures = 0;

    jtframe_rom_arb #(
        .AW      (AW),
        .OFFSET0 (OFF0),
        .OFFSET1 (OFF1),
        .OFFSET2 (OFF2),
        .OFFSET3 (OFF3)
    ) dut (
        .clk_rom     (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_addr  (sdram_addr),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        return {a[9:0], a} ^ 32'hA5C3_0F96;
    endfunction

    function automatic logic [21:0] get_addr(input int i);
        return slot_addr[i*22 +: 22];
    endfunction

    task automatic set_addr(input int i, input logic [21:0] a);
        slot_addr[i*22 +: 22] = a;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        downloading = 1'b0;
        loop_rst    = 1'b0;
        slot_cs     = 4'd0;
        slot_addr   = '0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        data_read   = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays the SDRAM controller for one transaction; returns the address requested.
    // rdy_dly == 0 asserts data_rdy together with ack.
    task automatic sdram_serve(input int ack_dly, input int rdy_dly,
                               output bit got, output logic [21:0] addr);
        got  = 1'b0;
        addr = '0;
        for (int c = 0; c < 50 && !sdram_req; c++) @(negedge clk);
        if (!sdram_req) return;
        got  = 1'b1;
        addr = sdram_addr;
        repeat (ack_dly) @(negedge clk);
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            data_rdy  = 1'b1;
            data_read = mem_word(addr);
        end
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) @(negedge clk);
            data_rdy  = 1'b1;
            data_read = mem_word(addr);
            @(negedge clk);
            data_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", sdram_req); end
        checks++; if (sdram_addr !== 22'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
        checks++; if (slot_dout !== 128'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", slot_dout); end
        checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL reset_refresh got=%b exp=1", refresh_en); end
        slot_cs = 4'hF;
        #1;
        checks++; if (slot_ok !== 4'd0) begin failures++; $display("FAIL reset_ok got=%b exp=0000", slot_ok); end
        slot_cs = 4'd0;
    endtask

    task automatic test_basic();
        do_reset();
        set_addr(0, 22'h000100);
        slot_cs = 4'b0001;
        @(negedge clk);
        checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL basic_req_c1 got=%b exp=1", sdram_req); end
        checks++; if (sdram_addr !== 22'h010100) begin failures++; $display("FAIL basic_addr got=%h exp=010100", sdram_addr); end
        checks++; if (refresh_en !== 1'b0) begin failures++; $display("FAIL basic_refresh got=%b exp=0", refresh_en); end
        @(negedge clk);
        checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL basic_req_hold got=%b exp=1", sdram_req); end
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", sdram_req); end
        repeat (2) @(negedge clk);
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL basic_ok_early got=%b exp=0000", slot_ok); end
        @(negedge clk);
        data_rdy = 1'b0;
        checks++; if (slot_ok !== 4'b0001) begin failures++; $display("FAIL basic_ok got=%b exp=0001", slot_ok); end
        checks++; if (slot_dout[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_dout got=%h exp=deadbeef", slot_dout[31:0]); end
    endtask

    task automatic test_hit();
        int reqs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sdram_req) reqs++;
        end
        checks++; if (reqs != 0) begin failures++; $display("FAIL hit_no_req got=%0d exp=0", reqs); end
        checks++; if (slot_ok !== 4'b0001) begin failures++; $display("FAIL hit_ok got=%b exp=0001", slot_ok); end
        checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL hit_refresh got=%b exp=1", refresh_en); end
        set_addr(0, 22'h000104);
        #1;
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL hit_miss_ok got=%b exp=0000", slot_ok); end
        set_addr(0, 22'h000100);
        #1;
        checks++; if (slot_ok !== 4'b0001) begin failures++; $display("FAIL hit_back_ok got=%b exp=0001", slot_ok); end
        slot_cs = 4'd0;
    endtask

    task automatic test_rr_order();
        bit got;
        logic [21:0] a;
        logic [21:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 22'h40 + 22'(i * 4));
        slot_cs = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sdram_serve(1, 2, got, a);
            e = 22'h40 + 22'(i * 4) + OFFS[i];
            checks++; if (!got || a !== e) begin failures++; $display("FAIL rr_grant%0d got=%h exp=%h", i, a, e); end
        end
        checks++; if (slot_ok !== 4'hF) begin failures++; $display("FAIL rr_all_ok got=%b exp=1111", slot_ok); end
        set_addr(1, 22'h84);
        set_addr(0, 22'h80);
        sdram_serve(0, 1, got, a);
        e = 22'h80 + OFF0;
        checks++; if (!got || a !== e) begin failures++; $display("FAIL rr_wrap0 got=%h exp=%h", a, e); end
        sdram_serve(2, 3, got, a);
        e = 22'h84 + OFF1;
        checks++; if (!got || a !== e) begin failures++; $display("FAIL rr_wrap1 got=%h exp=%h", a, e); end
        checks++; if (slot_dout[63:32] !== mem_word(e)) begin failures++; $display("FAIL rr_dout1 got=%h exp=%h", slot_dout[63:32], mem_word(e)); end
    endtask

    task automatic test_addr_change();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(2, 22'h20);
        slot_cs = 4'b0100;
        @(negedge clk);
        checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h20 + OFF2) begin failures++; $display("FAIL chg_req got=%b/%h exp=1/%h", sdram_req, sdram_addr, 22'h20 + OFF2); end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        set_addr(2, 22'h24);
        @(negedge clk);
        data_rdy  = 1'b1;
        data_read = mem_word(22'h20 + OFF2);
        @(negedge clk);
        data_rdy = 1'b0;
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL chg_no_stale got=%b exp=0000", slot_ok); end
        set_addr(2, 22'h20);
        #1;
        checks++; if (slot_ok !== 4'b0100) begin failures++; $display("FAIL chg_cached_old got=%b exp=0100", slot_ok); end
        checks++; if (slot_dout[95:64] !== mem_word(22'h20 + OFF2)) begin failures++; $display("FAIL chg_old_dout got=%h exp=%h", slot_dout[95:64], mem_word(22'h20 + OFF2)); end
        set_addr(2, 22'h24);
        sdram_serve(1, 1, got, a);
        checks++; if (!got || a !== 22'h24 + OFF2) begin failures++; $display("FAIL chg_rereq got=%h exp=%h", a, 22'h24 + OFF2); end
        checks++; if (slot_ok !== 4'b0100) begin failures++; $display("FAIL chg_new_ok got=%b exp=0100", slot_ok); end
    endtask

    task automatic test_download();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(0, 22'h100);
        slot_cs = 4'b0001;
        sdram_serve(1, 1, got, a);
        checks++; if (slot_ok !== 4'b0001) begin failures++; $display("FAIL dl_pre_ok got=%b exp=0001", slot_ok); end
        set_addr(3, 22'h300);
        slot_cs = 4'b1001;
        for (int c = 0; c < 10 && !sdram_req; c++) @(negedge clk);
        checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL dl_req_timeout got=%b exp=1", sdram_req); end
        downloading = 1'b1;
        @(negedge clk);
        downloading = 1'b0;
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL dl_req_drop got=%b exp=0", sdram_req); end
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL dl_ok_clear got=%b exp=0000", slot_ok); end
        slot_cs   = 4'd0;
        data_rdy  = 1'b1;
        data_read = 32'h1234_5678;
        @(negedge clk);
        data_rdy = 1'b0;
        slot_cs  = 4'b1001;
        #1;
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL dl_late_rdy got=%b exp=0000", slot_ok); end
        checks++; if (slot_dout[31:0] !== mem_word(22'h100 + OFF0)) begin failures++; $display("FAIL dl_dout_kept got=%h exp=%h", slot_dout[31:0], mem_word(22'h100 + OFF0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_addr(1, 22'h55);
        slot_cs = 4'b0010;
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        slot_cs   = 4'd0;
        data_rdy  = 1'b1;
        data_read = 32'hCAFE_F00D;
        @(negedge clk);
        data_rdy = 1'b0;
        slot_cs  = 4'b0010;
        #1;
        checks++; if (slot_ok !== 4'b0000) begin failures++; $display("FAIL rstmid_ok got=%b exp=0000", slot_ok); end
        checks++; if (slot_dout !== 128'd0) begin failures++; $display("FAIL rstmid_dout got=%h exp=0", slot_dout); end
        checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", sdram_req); end
    endtask

    task automatic test_ack_rdy_same();
        bit got;
        logic [21:0] a;
        logic [21:0] e;
        do_reset();
        set_addr(1, 22'h77);
        slot_cs = 4'b0010;
        sdram_serve(1, 0, got, a);
        e = 22'h77 + OFF1;
        checks++; if (!got || a !== e) begin failures++; $display("FAIL same_addr got=%h exp=%h", a, e); end
        checks++; if (slot_ok !== 4'b0010) begin failures++; $display("FAIL same_ok got=%b exp=0010", slot_ok); end
        checks++; if (slot_dout[63:32] !== mem_word(e)) begin failures++; $display("FAIL same_dout got=%h exp=%h", slot_dout[63:32], mem_word(e)); end
        @(negedge clk);
        checks++; if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin failures++; $display("FAIL same_idle got=req%b/ref%b exp=req0/ref1", sdram_req, refresh_en); end
    endtask

    task automatic test_random();
        bit          m_valid [4];
        logic [21:0] m_addr [4];
        logic [31:0] m_data [4];
        int          m_rr;
        logic [21:0] pool [4];
        logic [3:0]  exp_ok;
        logic [21:0] a;
        logic [21:0] e;
        bit          got;
        pool = '{22'h000010, 22'h000014, 22'h2AAAA8, 22'h3FFFFC};
        do_reset();
        m_rr = 3;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
        end
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(7) == 0) begin
                loop_rst = 1'b1;
                @(negedge clk);
                loop_rst = 1'b0;
                for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
            end
            slot_cs = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(1) == 1) set_addr(i, pool[$urandom_range(3)]);
            end
            for (int n = 0; n < 5; n++) begin
                int exp_slot;
                exp_slot = -1;
                for (int k = 1; k <= 4; k++) begin
                    int s;
                    s = (m_rr + k) % 4;
                    if (exp_slot < 0 && slot_cs[s] && !(m_valid[s] && m_addr[s] == get_addr(s))) exp_slot = s;
                end
                if (exp_slot < 0) break;
                e = get_addr(exp_slot) + OFFS[exp_slot];
                sdram_serve(int'($urandom_range(3)), int'($urandom_range(3)), got, a);
                checks++; if (!got || a !== e) begin failures++; $display("FAIL rand_grant r%0d slot%0d got=%h exp=%h", r, exp_slot, a, e); end
                m_valid[exp_slot] = 1'b1;
                m_addr[exp_slot]  = get_addr(exp_slot);
                m_data[exp_slot]  = mem_word(e);
                m_rr              = exp_slot;
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) exp_ok[i] = slot_cs[i] && m_valid[i] && (m_addr[i] == get_addr(i));
            checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL rand_idle_req r%0d got=%b exp=0", r, sdram_req); end
            checks++; if (slot_ok !== exp_ok) begin failures++; $display("FAIL rand_ok r%0d got=%b exp=%b", r, slot_ok, exp_ok); end
            checks++; if (refresh_en !== 1'b1) begin failures++; $display("FAIL rand_refresh r%0d got=%b exp=1", r, refresh_en); end
            for (int i = 0; i < 4; i++) begin
                if (exp_ok[i]) begin
                    checks++;
                    if (slot_dout[i*32 +: 32] !== m_data[i]) begin
                        failures++;
                        $display("FAIL rand_dout r%0d slot%0d got=%h exp=%h", r, i, slot_dout[i*32 +: 32], m_data[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hit();
        test_rr_order();
        test_addr_change();
        test_download();
        test_reset_mid();
        test_ack_rdy_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtframe_rom_arb.md
Name: jtframe_rom_arb

Overview:
- Round-robin arbiter that shares the single SDRAM ROM read port (sdram_req/ack/addr, data_read/data_rdy) among four game-side ROM requesters. Typical requesters are main CPU, sound CPU, char and object.
- Each slot keeps a one-word cache (last address plus 32-bit data), so repeated reads of the same word cost no SDRAM access.
- Sits between the game core ROM clients and the board SDRAM controller, in the clk_rom domain.

Parameters:
- AW, 22, address width of slot and SDRAM addresses.
- OFFSET0, 22'd0, word offset added to slot 0 address before issue.
- OFFSET1, 22'd0, word offset added to slot 1 address before issue.
- OFFSET2, 22'd0, word offset added to slot 2 address before issue.
- OFFSET3, 22'd0, word offset added to slot 3 address before issue.

Ports:
- clk_rom  in  1  sole clock; everything registered on rising edge.
- rst  in  1  synchronous, active-high reset.
- downloading  in  1  ROM load in progress; blocks grants and flushes caches.
- loop_rst  in  1  SDRAM controller init loop; same effect as downloading.
- slot_cs  in  4  per-slot read request, level.
- slot_addr  in  4*AW  slot i address at [i*AW +: AW].
- slot_ok  out  4  slot i data valid for the current slot_addr.
- slot_dout  out  128  slot i data at [i*32 +: 32].
- sdram_req  out  1  request to SDRAM controller.
- sdram_ack  in  1  controller accepted the request.
- sdram_addr  out  AW  request address (slot_addr + OFFSETi, modulo 2^AW).
- data_read  in  32  SDRAM read data.
- data_rdy  in  1  data_read valid, one-cycle strobe.
- refresh_en  out  1  high when arbiter is idle with nothing pending.

Behaviour:
- Reset values:
  - state IDLE, sdram_req=0, sdram_addr=0.
  - valid[3:0]=0, cached addrs=0, slot_dout=0.
  - rr pointer=3, so slot 0 has first priority.
  - refresh_en=1, slot_ok=0.
- hit[i] = valid[i] & (cache_addr[i]==slot_addr[i]).
- slot_ok[i] = slot_cs[i] & hit[i]. This is combinational from registered state, so the same-cycle address change is reflected.
- pending[i] = slot_cs[i] & ~hit[i].
- IDLE:
  - If any pending and not (downloading|loop_rst), grant the first pending slot after the rr pointer (wrapping 3->0).
  - Latch grant id and the slot's raw addr; set sdram_addr = addr+OFFSET and sdram_req=1; rr pointer = grant; go to REQ.
  - Latency: from pending visible at cycle 0, sdram_req is high at cycle 1.
- REQ:
  - Hold sdram_req and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0 next cycle, go to WAIT.
  - If data_rdy coincides with ack, complete directly (go to DONE action).
- WAIT:
  - On data_rdy, write data_read to slot_dout[grant], cache_addr[grant] = latched raw addr, valid[grant]=1; return to IDLE.
  - slot_ok can rise the cycle after data_rdy.
- data_rdy outside REQ+ack or WAIT is ignored.
- One transaction in flight at most.
- The next grant may issue in the cycle after completion (IDLE evaluates immediately).
- Slot address changes during a transaction:
  - Data is still cached under the latched address.
  - The new address misses and is re-requested later in rr order. No stale data is flagged ok.
- slot_cs dropped mid-transaction: the transaction completes and is cached; it is not cancelled.
- downloading or loop_rst high:
  - Next cycle: state IDLE, sdram_req=0, all valid cleared (slot_ok=0).
  - slot_dout keeps its value; no grants while high.
- rst mid-transaction: same as reset values; any later data_rdy is ignored.
- refresh_en = (state==IDLE) & ~|pending. It is registered and follows one cycle later.

Test Plan:
- Slot 0 cs=1, addr=0x000100, OFFSET0=0x010000 -> sdram_req at cycle 1 with sdram_addr=0x010100; ack at 3, data_rdy with 0xDEADBEEF at 6 -> slot_ok[0]=1 and slot_dout[0]=0xDEADBEEF at cycle 7.
- Repeat the same slot 0 addr -> slot_ok[0]=1 immediately, no sdram_req (hit).
- All four slots pending simultaneously from reset -> grant order 0,1,2,3, then a new slot 1 miss followed by slot 0 miss -> grant order 0 then 1 (pointer at 3 wraps to 0).
- Slot 2 changes addr 0x20->0x24 while in WAIT -> data cached for 0x20, slot_ok[2] stays 0, second request issued for 0x24.
- downloading pulsed in REQ -> sdram_req=0 next cycle, all slot_ok=0, data_rdy arriving afterwards leaves valid=0.
- ack and data_rdy asserted in the same cycle -> transaction completes, slot_ok high next cycle, arbiter back in IDLE.
